inst_fetch_queue: RTL and testbench

//  Fetch stage upstream of inst_memory: owns the PC, drives the instruction memory read

---
 rtl/inst_fetch_queue_pkg.sv | 31 +++
 rtl/inst_fetch_queue_fifo.sv | 77 +++++++
 rtl/inst_fetch_queue.sv | 85 ++++++++
 tb/tb_inst_fetch_queue.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// ============================================================================
// Module      : inst_fetch_queue_pkg
// Description : Shared types and constants for the instruction fetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package inst_fetch_queue_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] INST_BYTES = 64'd4;

    typedef logic [XLEN-1:0] dataBus_t;

    typedef union packed {
        logic [ILEN-1:0] raw;
        struct packed {
            logic [24:0] payload;
            logic [6:0]  opcode;
        } fields;
    } instruction_u;

    typedef struct packed {
        dataBus_t     pc;
        instruction_u inst;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/inst_fetch_queue_fifo.sv
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous FIFO with flush, clock enable and async reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
    import inst_fetch_queue_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     clk_en,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  T                         wr_data,
    output T                         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    T                r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_pop  = pop & ~empty;
    // A push into a full queue is only accepted alongside a pop.
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clk_en) begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
                if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
                case ({w_do_push, w_do_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clk_en && !flush && w_do_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Storage is not reset, so the head reads as zero whenever nothing is queued.
    assign head  = empty ? T'(0) : r_mem[r_rd_ptr];
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/inst_fetch_queue.sv
// ============================================================================
// Module      : inst_fetch_queue
// Description : Fetch stage: PC register, imem request, redirect, fetch FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           clk_en,
    input  logic                           rst_n,
    output logic                           imem_rd_en,
    output dataBus_t                       imem_addr,
    input  instruction_u                   imem_inst,
    input  logic                           imem_ready,
    input  logic                           redirect_en,
    input  dataBus_t                       redirect_pc,
    output logic                           if_valid,
    input  logic                           if_ready,
    output dataBus_t                       if_pc,
    output instruction_u                   if_inst,
    output logic [$clog2(QUEUE_DEPTH):0]   if_count
);

    dataBus_t      r_pc;
    dataBus_t      w_redirect_aligned;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    fetch_entry_t  w_wr_entry;
    fetch_entry_t  w_head;

    assign w_redirect_aligned = redirect_pc & ~dataBus_t'(3);

    assign w_pop      = if_valid & if_ready;
    assign imem_rd_en = rst_n & ~redirect_en & (~w_full | w_pop);
    assign w_push     = imem_rd_en & imem_ready;
    assign imem_addr  = r_pc >> 2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (clk_en) begin
            if (redirect_en) begin
                r_pc <= w_redirect_aligned;
            end else if (w_push) begin
                r_pc <= r_pc + INST_BYTES;
            end
        end
    end

    assign w_wr_entry.pc   = r_pc;
    assign w_wr_entry.inst = imem_inst;

    // Redirect flushes the queue; the head popped in that cycle is discarded.
    fetch_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk     (clk),
        .clk_en  (clk_en),
        .rst_n   (rst_n),
        .push    (w_push),
        .pop     (w_pop & ~redirect_en),
        .flush   (redirect_en),
        .wr_data (w_wr_entry),
        .head    (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (if_count)
    );

    assign if_valid = ~w_empty;
    assign if_pc    = w_head.pc;
    assign if_inst  = w_head.inst;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
// ============================================================================
// Module      : tb_inst_fetch_queue
// Description : Self-checking bench with a queue-based fetch reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [63:0] RPC   = 64'h100;

    logic        clk = 1'b0;
    logic        clk_en, rst_n;
    logic        imem_rd_en, imem_ready;
    logic [63:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect_en;
    logic [63:0] redirect_pc;
    logic        if_valid, if_ready;
    logic [63:0] if_pc;
    logic [31:0] if_inst;
    logic [2:0]  if_count;

    int asserts = 0;
    int fails   = 0;

    logic [95:0] q [$];
    logic [63:0] mpc;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] widx);
        return (widx[31:0] * 32'h9E37_79B1) ^ widx[63:32] ^ 32'h0000_0013;
    endfunction

    assign imem_inst = mem_word(imem_addr);

    inst_fetch_queue #(.RESET_PC(RPC), .QUEUE_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .clk_en      (clk_en),
        .rst_n       (rst_n),
        .imem_rd_en  (imem_rd_en),
        .imem_addr   (imem_addr),
        .imem_inst   (imem_inst),
        .imem_ready  (imem_ready),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .if_count    (if_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        asserts++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare all outputs against the model, then advance the model across one edge.
    task automatic tick();
        bit pop, rd;
        #2;
        pop = (q.size() > 0) && if_ready;
        rd  = !redirect_en && ((q.size() < DEPTH) || pop);
        chk("if_valid",   {63'd0, if_valid},   {63'd0, q.size() > 0});
        chk("if_count",   {61'd0, if_count},   64'(q.size()));
        chk("imem_rd_en", {63'd0, imem_rd_en}, {63'd0, rd});
        chk("imem_addr",  imem_addr,           mpc >> 2);
        if (q.size() > 0) begin
            chk("if_pc",   if_pc,          q[0][95:32]);
            chk("if_inst", {32'd0, if_inst}, {32'd0, q[0][31:0]});
        end
        if (clk_en) begin
            if (redirect_en) begin
                q.delete();
                mpc = redirect_pc & ~64'h3;
            end else begin
                if (pop) q.delete(0);
                if (rd && imem_ready) begin
                    q.push_back({mpc, mem_word(mpc >> 2)});
                    mpc = mpc + 64'd4;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [63:0] target);
        redirect_en = 1'b1;
        redirect_pc = target;
        tick();
        redirect_en = 1'b0;
    endtask

    initial begin
        clk_en = 1'b1; rst_n = 1'b0; imem_ready = 1'b1; if_ready = 1'b1;
        redirect_en = 1'b0; redirect_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {63'd0, if_valid},   64'd0);
        chk("rst_count", {61'd0, if_count},   64'd0);
        chk("rst_pc",    if_pc,               64'd0);
        chk("rst_inst",  {32'd0, if_inst},    64'd0);
        chk("rst_rd_en", {63'd0, imem_rd_en}, 64'd0);
        chk("rst_addr",  imem_addr,           RPC >> 2);
        rst_n = 1'b1;
        mpc = RPC;

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("seq_pc", if_pc, RPC + 64'(4 * i));
        end

        do_redirect(64'h100);
        if_ready = 1'b0;
        repeat (10) tick();
        chk("stall_count", {61'd0, if_count},   64'd4);
        chk("stall_rd_en", {63'd0, imem_rd_en}, 64'd0);
        chk("stall_addr",  imem_addr,           64'h110 >> 2);
        chk("stall_head",  if_pc,               64'h100);
        if_ready = 1'b1;
        tick();
        chk("full_pp_pc",    if_pc,             64'h104);
        chk("full_pp_count", {61'd0, if_count}, 64'd4);
        repeat (6) tick();
        chk("full_steady",   {61'd0, if_count}, 64'd4);

        do_redirect(64'h100);
        if_ready = 1'b0;
        repeat (3) tick();
        chk("three_count", {61'd0, if_count}, 64'd3);
        if_ready = 1'b1;
        do_redirect(64'h203);
        chk("redir_valid", {63'd0, if_valid}, 64'd0);
        chk("redir_count", {61'd0, if_count}, 64'd0);
        chk("redir_addr",  imem_addr,         64'h200 >> 2);
        tick();
        chk("redir_pc",    if_pc,             64'h200);

        imem_ready = 1'b0;
        repeat (3) tick();
        imem_ready = 1'b1;
        repeat (4) tick();

        clk_en = 1'b0;
        repeat (5) tick();
        clk_en = 1'b1;
        repeat (3) tick();

        do_redirect(64'hFFFF_FFFF_FFFF_FFF8);
        repeat (6) tick();

        for (int i = 0; i < 400; i++) begin
            if_ready    = ($urandom_range(0, 3) != 0);
            imem_ready  = ($urandom_range(0, 4) != 0);
            clk_en      = ($urandom_range(0, 9) != 0);
            redirect_en = ($urandom_range(0, 19) == 0);
            redirect_pc = {$urandom, $urandom};
            if (i % 50 == 0) if_ready = 1'b0;
            tick();
        end
        redirect_en = 1'b0; clk_en = 1'b1; if_ready = 1'b1; imem_ready = 1'b1;
        repeat (3) tick();

        rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'd0, if_valid},   64'd0);
        chk("arst_count", {61'd0, if_count},   64'd0);
        chk("arst_pc",    if_pc,               64'd0);
        chk("arst_rd_en", {63'd0, imem_rd_en}, 64'd0);
        chk("arst_addr",  imem_addr,           RPC >> 2);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

`default_nettype wire
